// File: rtl/tokenizer.sv
// tokenizer: skips whitespace from a start address, returns the next token span and
// NUL-terminates it in place by overwriting the delimiter.
module tokenizer #(
  parameter int ASZ = 17,
  parameter int DSZ = 8,
  parameter int MAXLEN = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [ASZ-1:0] ptr,
  output logic           bsy,
  output logic           done,
  output logic [ASZ-1:0] adr,
  output logic [5:0]     len,
  output logic [ASZ-1:0] nxt,
  output logic           eol,
  output logic           err,
  output logic           we,
  output logic [ASZ-1:0] ai,
  output logic [DSZ-1:0] vi,
  input  logic [DSZ-1:0] vo
);
  localparam logic [2:0] IDLE = 3'd0, SKIP = 3'd1, SCAN = 3'd2, TERM = 3'd3, DONE = 3'd4;
  logic [2:0] st;
  logic [ASZ-1:0] p, dlm, ba;
  logic fl, tz, ws;
  // the byte on vo was fetched from the address presented one cycle ago
  assign ba = p - ASZ'(1);
  assign tz = vo == '0;
  assign ws = !tz && vo <= DSZ'(32);
  assign bsy = st != IDLE;
  assign done = st == DONE;
  // gated by rst so a reset landing on the TERM cycle leaves memory untouched
  assign we = st == TERM && !rst;
  assign ai = st == TERM ? dlm : p;
  assign vi = '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      p <= '0;
      dlm <= '0;
      fl <= 1'b0;
      adr <= '0;
      len <= '0;
      nxt <= '0;
      eol <= 1'b0;
      err <= 1'b0;
    end else begin
      case (st)
        IDLE: if (en) begin
          st <= SKIP;
          p <= ptr;
          fl <= 1'b1;
          eol <= 1'b0;
          err <= 1'b0;
        end
        SKIP: begin
          p <= p + ASZ'(1);
          fl <= 1'b0;
          if (!fl && tz) begin
            eol <= 1'b1;
            len <= '0;
            nxt <= ba;
            st <= DONE;
          end else if (!fl && !ws) begin
            adr <= ba;
            len <= 6'd1;
            st <= SCAN;
          end
        end
        SCAN: begin
          p <= p + ASZ'(1);
          if (tz) begin
            nxt <= ba;
            st <= DONE;
          end else if (ws) begin
            dlm <= ba;
            st <= TERM;
          end else if (len == 6'(MAXLEN)) begin
            err <= 1'b1;
            nxt <= ba;
            st <= DONE;
          end else len <= len + 6'd1;
        end
        TERM: begin
          nxt <= dlm + ASZ'(1);
          st <= DONE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tokenizer.sv
// tb_tokenizer: directed and randomized parses against a byte-array reference model.
module tb_tokenizer;
  logic clk = 0, rst = 1, en = 0;
  logic [16:0] ptr = '0, adr, nxt, ai;
  logic bsy, done, eol, err, we;
  logic [5:0] len;
  logic [7:0] vi, vo;
  logic [7:0] mem [0:131071];
  logic lw = 0;
  logic [16:0] la = '0, wa = '0;
  logic [7:0] ld = '0;
  int wcnt = 0, compared = 0, mismatched = 0;
  logic [16:0] e_adr, e_nxt, e_wa;
  logic [5:0] e_len;
  logic e_eol, e_err, e_wr;
  int e_lat;

  tokenizer dut (.clk(clk), .rst(rst), .en(en), .ptr(ptr), .bsy(bsy), .done(done),
    .adr(adr), .len(len), .nxt(nxt), .eol(eol), .err(err), .we(we), .ai(ai), .vi(vi), .vo(vo));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vo <= mem[ai];
    if (we) begin
      mem[ai] <= vi;
      wa <= ai;
      wcnt <= wcnt + 1;
    end else if (lw) mem[la] <= ld;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [16:0] a, input logic [7:0] d);
    lw = 1; la = a; ld = d;
    @(posedge clk); #1;
    lw = 0;
  endtask

  task automatic load(input logic [16:0] a, input string s);
    for (int i = 0; i < s.len(); i++) put(a + 17'(i), s[i]);
    put(a + 17'(s.len()), 8'h00);
  endtask

  // Reference: walk the byte array by the classification rules.
  task automatic model(input logic [16:0] p0);
    logic [16:0] a, d;
    int l;
    a = p0; l = 0;
    e_eol = 0; e_err = 0; e_wr = 0; e_wa = '0; e_adr = '0; e_len = '0; e_nxt = '0;
    while (mem[a] != 0 && mem[a] <= 8'h20) a++;
    if (mem[a] == 0) begin
      e_eol = 1; e_nxt = a;
    end else begin
      e_adr = a;
      while (1) begin
        if (mem[a] == 0) begin e_nxt = a; break; end
        else if (mem[a] <= 8'h20) begin e_wr = 1; e_wa = a; e_nxt = a + 1; break; end
        else if (l == 31) begin e_err = 1; e_nxt = a; break; end
        l++; a++;
      end
      e_len = 6'(l);
    end
    d = a - p0;
    e_lat = int'(d) + 2 + int'(e_wr);
  endtask

  task automatic parse(input logic [16:0] pp, input int inj, output int k);
    en = 1; ptr = pp;
    @(posedge clk); #1;
    en = 0; k = 0;
    while (!done && k < 300) begin
      en = (k == inj); ptr = pp + 17'd6;
      @(posedge clk); #1;
      k++;
    end
    en = 0;
    chk("done_seen", done, 1);
  endtask

  task automatic verify(input string tag, input logic [16:0] pp, input int inj);
    int k, w0;
    model(pp);
    w0 = wcnt;
    parse(pp, inj, k);
    chk({tag, "_lat"}, k, e_lat);
    chk({tag, "_len"}, len, e_len);
    chk({tag, "_nxt"}, nxt, e_nxt);
    chk({tag, "_eol"}, eol, e_eol);
    chk({tag, "_err"}, err, e_err);
    if (!e_eol) chk({tag, "_adr"}, adr, e_adr);
    chk({tag, "_wcnt"}, wcnt - w0, int'(e_wr));
    if (e_wr) begin
      chk({tag, "_wa"}, wa, e_wa);
      chk({tag, "_wdat"}, mem[e_wa], 0);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {bsy, done}, 0);
    chk({tag, "_hold"}, {adr, len, nxt}, {(e_eol ? adr : e_adr), e_len, e_nxt});
  endtask

  initial begin
    int k, w0;
    logic [31:0] tk;
    logic [16:0] base;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {bsy, done, we, eol, err}, 0);
    chk("rst_len", len, 0);
    chk("rst_adr", {adr, nxt, ai}, 0);
    chk("rst_vi", vi, 0);
    rst = 0;

    load(17'h0, "  abcd efg");
    verify("t1", 17'h0, -1);
    chk("t1_const", {adr, len, nxt, wa}, {17'd2, 6'd4, 17'd7, 17'd6});
    verify("t2", 17'd7, -1);
    chk("t2_const", {adr, len, nxt}, {17'd7, 6'd3, 17'd10});
    verify("t3", 17'd10, -1);
    chk("t3_const", {eol, len, nxt}, {1'b1, 6'd0, 17'd10});

    load(17'h10, "abcd");
    verify("t4", 17'h10, -1);
    chk("t4_lat", e_lat, 6);
    tk = '0;
    for (int i = 0; i < 4; i++) tk = {tk[23:0], mem[adr + 17'(i)]};
    chk("t4_find", {len, tk}, {6'd4, "abcd"});

    for (int i = 0; i < 40; i++) put(17'h100 + 17'(i), "x");
    put(17'h128, 8'h00);
    verify("t5", 17'h100, -1);
    chk("t5_const", {err, len, nxt}, {1'b1, 6'd31, 17'h11F});

    put(17'h1FFFE, "a"); put(17'h1FFFF, "b"); put(17'h0, " ");
    verify("wrap", 17'h1FFFE, -1);
    chk("wrap_const", {adr, nxt}, {17'h1FFFE, 17'd1});

    load(17'h200, "  abcd efg");
    w0 = wcnt;
    en = 1; ptr = 17'h200;
    @(posedge clk); #1;
    en = 0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    chk("rs_scan_bsy", {bsy, done, we}, 0);
    rst = 0;
    en = 1; ptr = 17'h200;
    @(posedge clk); #1;
    en = 0; k = 0;
    while (!we && k < 50) begin @(posedge clk); #1; k++; end
    chk("rs_term_seen", k < 50, 1);
    rst = 1;
    #1;
    chk("rs_term_we", we, 0);
    @(posedge clk); #1;
    chk("rs_term_bsy", {bsy, we}, 0);
    rst = 0;
    chk("rs_wcnt", wcnt - w0, 0);
    chk("rs_mem", mem[17'h206], 8'h20);
    verify("fresh", 17'h200, -1);

    load(17'h300, "hello world");
    verify("busy_en", 17'h300, 3);
    chk("busy_const", {adr, len}, {17'h300, 6'd5});
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_idle", bsy, 0);

    for (int it = 0; it < 10; it++) begin
      base = 17'($urandom_range(17'h1000, 17'h1F000));
      n = $urandom_range(20, 60);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 9);
        if (it % 3 == 0 && i < 40) put(base + 17'(i), 8'h41 + 8'($urandom_range(0, 25)));
        else if (k < 3) put(base + 17'(i), k == 0 ? 8'h09 : 8'h20);
        else put(base + 17'(i), 8'h21 + 8'($urandom_range(0, 93)));
      end
      put(base + 17'(n), 8'h00);
      verify($sformatf("rnd%0d", it), base + 17'($urandom_range(0, n / 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
